// File: rtl/multdiv_seq_unit.sv
// multdiv_seq_unit -- iterative signed multiply/divide for the execute stage.
//
// One op per accepted start. Each RUN cycle does one radix-2 step: a shift-add for
// multiply, a restoring step for divide. WIDTH steps, then one DONE cycle presents
// the result. stall_o holds the pipeline from the accept cycle until DONE.
//
// Optional build macro: MULTDIV_ZERO_SKIP_EN. When it is defined, a zero operand
// (and a zero divisor) finishes on the edge after the accept. The results are the
// same as in the default build.
//
// Ports:
//   clock_i          rising-edge clock
//   reset_i          asynchronous reset, active low
//   start_i          request; accepted in IDLE or DONE when abort_i is low
//   op_div_i         0 = multiply, 1 = divide (sampled with start_i)
//   operand_a_i      multiplicand / dividend, two's complement
//   operand_b_i      multiplier / divisor, two's complement
//   abort_i          flush; cancels an op that is running
//   stall_o          combinational pipeline freeze
//   busy_o           registered, high while RUN
//   result_o         registered result, held between ops
//   result_valid_o   one-cycle pulse in DONE
//   exception_o      overflow or divide-by-zero, held with result_o
module multdiv_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic [WIDTH-1:0] operand_a_i,
    input  logic [WIDTH-1:0] operand_b_i,
    input  logic             abort_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic             result_valid_o,
    output logic             exception_o
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    // Magnitude 2**(WIDTH-1) is the largest possible product magnitude bound per operand.
    localparam logic [2*WIDTH-1:0] MUL_LIM = (2*WIDTH)'(1) << (WIDTH-1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;    // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]     opb_q;    // multiplicand magnitude or divisor magnitude
    logic                 sign_q, div_q, bzero_q;
    logic [WIDTH-1:0]     result_q;
    logic                 valid_q, exc_q, busy_q;

    logic                 accept;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       mul_sum, div_t;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   step;
    logic [WIDTH-1:0]     mul_res, div_res, fin_res;
    logic                 mul_ovf, div_exc, fin_exc;

    // abort wins over start; a start while RUN is ignored.
    assign accept  = start_i & ~abort_i & (state_q != S_RUN);
    assign stall_o = reset_i & (accept | (state_q == S_RUN));

    // |MIN| = 2**(WIDTH-1) is exact as an unsigned WIDTH-bit magnitude.
    assign a_mag = operand_a_i[WIDTH-1] ? (~operand_a_i + WIDTH'(1)) : operand_a_i;
    assign b_mag = operand_b_i[WIDTH-1] ? (~operand_b_i + WIDTH'(1)) : operand_b_i;

    // One iteration step for each operation.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign div_t   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge  = div_t >= {1'b0, opb_q};
    assign div_rem = div_ge ? WIDTH'(div_t - {1'b0, opb_q}) : div_t[WIDTH-1:0];
    assign step    = div_q ? {div_rem, acc_q[WIDTH-2:0], div_ge}
                           : {mul_sum, acc_q[WIDTH-1:1]};

    // Final sign and exception, computed from the last step so that DONE can register them.
    assign mul_res = sign_q ? (~step[WIDTH-1:0] + WIDTH'(1)) : step[WIDTH-1:0];
    assign mul_ovf = sign_q ? (step > MUL_LIM) : (step >= MUL_LIM);
    assign div_res = bzero_q ? '0 : mul_res;  // quotient is in the low half as well
    // An unsigned quotient of 2**(WIDTH-1) with a positive sign only comes from MIN / -1.
    assign div_exc = bzero_q | (~sign_q & step[WIDTH-1]);
    assign fin_res = div_q ? div_res : mul_res;
    assign fin_exc = div_q ? div_exc : mul_ovf;

`ifdef MULTDIV_ZERO_SKIP_EN
    logic a_zero, b_zero, skip;
    assign a_zero = operand_a_i == '0;
    assign b_zero = operand_b_i == '0;
    assign skip   = op_div_i ? (a_zero | b_zero) : (a_zero | b_zero);
`endif

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            sign_q   <= 1'b0;
            div_q    <= 1'b0;
            bzero_q  <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            exc_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        acc_q   <= {{WIDTH{1'b0}}, op_div_i ? a_mag : b_mag};
                        opb_q   <= op_div_i ? b_mag : a_mag;
                        sign_q  <= operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1];
                        div_q   <= op_div_i;
                        bzero_q <= operand_b_i == '0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
`ifdef MULTDIV_ZERO_SKIP_EN
                        if (skip) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            result_q <= '0;
                            exc_q    <= op_div_i & b_zero;
                        end
`endif
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH-1)) begin
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            valid_q  <= 1'b1;
                            result_q <= fin_res;
                            exc_q    <= fin_exc;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign exception_o    = exc_q;
endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Directed bench for multdiv_seq_unit at WIDTH=32. Every input is driven 1 time unit
// after a rising edge, and every output is sampled in the same place.
module tb_multdiv_seq_unit;
    localparam int W = 32;

    logic         clock_i = 1'b0;
    logic         reset_i, start_i, op_div_i, abort_i;
    logic [W-1:0] operand_a_i, operand_b_i;
    logic         stall_o, busy_o, result_valid_o, exception_o;
    logic [W-1:0] result_o;

    int passed = 0;
    int total  = 0;

    multdiv_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .op_div_i(op_div_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .abort_i(abort_i),
        .stall_o(stall_o), .busy_o(busy_o), .result_o(result_o),
        .result_valid_o(result_valid_o), .exception_o(exception_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Drives the request in cycle 0 and checks the stall in that cycle. Returns in cycle 1.
    task automatic launch(input logic div, input logic [W-1:0] a, input logic [W-1:0] b);
        start_i = 1'b1; op_div_i = div; operand_a_i = a; operand_b_i = b;
        #1;
        chk("stall_cycle0", {63'd0, stall_o}, 64'd1);
        tick();
        start_i = 1'b0; operand_a_i = '0; operand_b_i = '0;
    endtask

    // Enters at cycle `from`, walks through the RUN cycles, and checks DONE at cycle W+1.
    task automatic finish_op(input string tag, input int from,
                             input logic [W-1:0] er, input logic ee);
        int bad = 0;
        for (int c = from; c <= W; c++) begin
            if (!(stall_o === 1'b1 && busy_o === 1'b1 && result_valid_o === 1'b0)) bad++;
            tick();
        end
        chk({tag, "_run"},   64'(bad), 64'd0);
        chk({tag, "_valid"}, {63'd0, result_valid_o}, 64'd1);
        chk({tag, "_res"},   {32'd0, result_o}, {32'd0, er});
        chk({tag, "_exc"},   {63'd0, exception_o}, {63'd0, ee});
        chk({tag, "_stall"}, {62'd0, stall_o, busy_o}, 64'd0);
    endtask

    initial begin
        reset_i = 1'b0; start_i = 1'b1; op_div_i = 1'b0; abort_i = 1'b0;
        operand_a_i = 32'd1; operand_b_i = 32'd1;
        #12;
        chk("reset_outs", {result_o, 29'd0, result_valid_o, exception_o, busy_o}, 64'd0);
        chk("reset_stall", {63'd0, stall_o}, 64'd0);
        start_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();

        // Basic multiply and divide sign handling.
        launch(1'b0, 32'd7, -32'sd6);
        finish_op("mul_7x-6", 1, 32'hFFFFFFD6, 1'b0);
        tick();
        chk("valid_pulse", {63'd0, result_valid_o}, 64'd0);
        launch(1'b1, 32'd100, -32'sd7);
        finish_op("div_100/-7", 1, 32'hFFFFFFF2, 1'b0);
        tick();
        launch(1'b1, -32'sd100, 32'd7);
        finish_op("div_-100/7", 1, 32'hFFFFFFF2, 1'b0);
        tick();

        // Exception corners and representable extremes.
        launch(1'b1, 32'd5, 32'd0);
        finish_op("div_by0", 1, 32'd0, 1'b1);
        tick();
        launch(1'b0, 32'h40000000, 32'd4);
        finish_op("mul_ovf", 1, 32'd0, 1'b1);
        tick();
        launch(1'b1, 32'h80000000, 32'hFFFFFFFF);
        finish_op("div_min/-1", 1, 32'h80000000, 1'b1);
        tick();
        launch(1'b0, 32'h80000000, 32'd1);
        finish_op("mul_minx1", 1, 32'h80000000, 1'b0);
        tick();
        launch(1'b1, -32'sd7, 32'd2);
        finish_op("div_-7/2", 1, 32'hFFFFFFFD, 1'b0);
        tick();

        // An abort together with a start is not accepted.
        start_i = 1'b1; abort_i = 1'b1; operand_a_i = 32'd9; operand_b_i = 32'd9;
        #1;
        chk("abort_start_stall", {63'd0, stall_o}, 64'd0);
        tick();
        start_i = 1'b0; abort_i = 1'b0;
        chk("abort_start_busy", {63'd0, busy_o}, 64'd0);

        // An abort in RUN returns to IDLE and leaves the previous result in place.
        launch(1'b0, 32'd3, 32'd3);
        for (int i = 1; i < 10; i++) tick();
        abort_i = 1'b1;
        #1;
        chk("abort_c10_stall", {63'd0, stall_o}, 64'd1);
        tick();
        abort_i = 1'b0;
        chk("abort_c11", {62'd0, busy_o, stall_o}, 64'd0);
        chk("abort_novalid", {63'd0, result_valid_o}, 64'd0);
        chk("abort_keep", {31'd0, exception_o, result_o}, {31'd0, 1'b0, 32'hFFFFFFFD});
        launch(1'b0, 32'd3, 32'd3);
        finish_op("mul_3x3", 1, 32'd9, 1'b0);
        tick();

        // A start while busy is ignored. A start in DONE runs back to back.
        launch(1'b0, 32'd5, 32'd6);
        for (int i = 1; i < 4; i++) tick();
        start_i = 1'b1; op_div_i = 1'b1; operand_a_i = 32'd100; operand_b_i = 32'd100;
        tick();
        start_i = 1'b0; op_div_i = 1'b0;
        finish_op("mul_5x6", 5, 32'd30, 1'b0);
        launch(1'b1, -32'sd9, 32'd4);
        chk("b2b_busy", {62'd0, busy_o, result_valid_o}, 64'd2);
        finish_op("b2b_div", 1, 32'hFFFFFFFE, 1'b0);
        tick();

        // A reset in the middle of a divide clears everything immediately.
        launch(1'b1, 32'd1000, 32'd3);
        for (int i = 1; i < 15; i++) tick();
        chk("pre_reset_busy", {63'd0, busy_o}, 64'd1);
        reset_i = 1'b0;
        #1;
        chk("midrun_reset", {result_o, 28'd0, result_valid_o, exception_o, busy_o, stall_o},
            64'd0);
        tick();
        reset_i = 1'b1;
        tick();

`ifdef MULTDIV_ZERO_SKIP_EN
        launch(1'b0, 32'd0, 32'd123);
        chk("skip_valid", {63'd0, result_valid_o}, 64'd1);
        chk("skip_res", {31'd0, exception_o, result_o}, 64'd0);
`else
        launch(1'b0, 32'd0, 32'd123);
        finish_op("mul_0x123", 1, 32'd0, 1'b0);
`endif
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
